// File: rtl/game_status_manager.sv
// Game-level state for the space shooter: score, lives, kill count and phase.
// Per-pixel collision levels are folded into one event per kind per frame and
// committed on startOfFrame; all outputs are registered except the decodes.
module game_status_manager #(
    parameter int unsigned INIT_LIVES      = 3,
    parameter int unsigned LIVES_W         = 2,
    parameter int unsigned SCORE_W         = 12,
    parameter int unsigned POINTS_PER_KILL = 10,
    parameter int unsigned MONSTER_COUNT   = 24,
    parameter int unsigned KILL_W          = 5,
    parameter int unsigned COOLDOWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startKey,
    input  logic               monsterKill,
    input  logic               shipHit,
    input  logic               collisionGameOver,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [KILL_W-1:0]  kills,
    output logic [2:0]         phase,
    output logic               gameActive,
    output logic               newGamePulse,
    output logic               lifeLostPulse,
    output logic               shipBlink
);

    // Counter needs bit 2 for the blink even with a tiny cooldown.
    localparam int unsigned CNT_W = ($clog2(COOLDOWN_FRAMES) < 3) ? 3 : $clog2(COOLDOWN_FRAMES);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlaying  = 3'd1,
        StCooldown = 3'd2,
        StGameOver = 3'd3,
        StWin      = 3'd4
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [KILL_W-1:0]  kills_q, kills_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               kill_l_q, kill_l_d;
    logic               hit_l_q, hit_l_d;
    logic               over_l_q, over_l_d;
    logic               start_key_q, start_key_d;
    logic               new_game_q, new_game_d;
    logic               life_lost_q, life_lost_d;

    logic               start_rise;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [KILL_W-1:0]  kills_inc;
    logic               game_lost;

    assign start_rise = startKey & ~start_key_q;
    assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_KILL);
    assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign kills_inc  = (kills_q < KILL_W'(MONSTER_COUNT)) ? kills_q + KILL_W'(1) : kills_q;

    // Next-state: event latching, frame commit and new-game handling.
    always_comb begin
        phase_d     = phase_q;
        score_d     = score_q;
        lives_d     = lives_q;
        kills_d     = kills_q;
        cnt_d       = cnt_q;
        start_key_d = startKey;
        new_game_d  = 1'b0;
        life_lost_d = 1'b0;
        game_lost   = 1'b0;
        // A level seen in the commit cycle itself belongs to the next frame.
        kill_l_d    = startOfFrame ? monsterKill       : (kill_l_q | monsterKill);
        hit_l_d     = startOfFrame ? shipHit           : (hit_l_q | shipHit);
        over_l_d    = startOfFrame ? collisionGameOver : (over_l_q | collisionGameOver);

        unique case (phase_q)
            StIdle, StGameOver, StWin: begin
                if (start_rise) begin
                    phase_d    = StPlaying;
                    score_d    = '0;
                    lives_d    = LIVES_W'(INIT_LIVES);
                    kills_d    = '0;
                    cnt_d      = '0;
                    kill_l_d   = 1'b0;
                    hit_l_d    = 1'b0;
                    over_l_d   = 1'b0;
                    new_game_d = 1'b1;
                end
            end
            StPlaying, StCooldown: begin
                if (startOfFrame) begin
                    if (kill_l_q) begin
                        score_d = score_sat;
                        kills_d = kills_inc;
                    end
                    if (over_l_q) begin
                        phase_d   = StGameOver;
                        game_lost = 1'b1;
                    end else if (hit_l_q && (phase_q == StPlaying)) begin
                        if (lives_q != '0) begin
                            lives_d     = lives_q - LIVES_W'(1);
                            life_lost_d = 1'b1;
                        end
                        if (lives_q <= LIVES_W'(1)) begin
                            phase_d   = StGameOver;
                            game_lost = 1'b1;
                        end else begin
                            phase_d = StCooldown;
                            cnt_d   = CNT_W'(COOLDOWN_FRAMES - 1);
                        end
                    end else if (phase_q == StCooldown) begin
                        if (cnt_q == '0) begin
                            phase_d = StPlaying;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    if (kill_l_q && (kills_inc == KILL_W'(MONSTER_COUNT)) && !game_lost) begin
                        phase_d = StWin;
                    end
                end
            end
            default: phase_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_q     <= StIdle;
            score_q     <= '0;
            lives_q     <= LIVES_W'(INIT_LIVES);
            kills_q     <= '0;
            cnt_q       <= '0;
            kill_l_q    <= 1'b0;
            hit_l_q     <= 1'b0;
            over_l_q    <= 1'b0;
            start_key_q <= 1'b0;
            new_game_q  <= 1'b0;
            life_lost_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            kills_q     <= kills_d;
            cnt_q       <= cnt_d;
            kill_l_q    <= kill_l_d;
            hit_l_q     <= hit_l_d;
            over_l_q    <= over_l_d;
            start_key_q <= start_key_d;
            new_game_q  <= new_game_d;
            life_lost_q <= life_lost_d;
        end
    end

    assign score         = score_q;
    assign lives         = lives_q;
    assign kills         = kills_q;
    assign phase         = phase_q;
    assign gameActive    = (phase_q == StPlaying) || (phase_q == StCooldown);
    assign newGamePulse  = new_game_q;
    assign lifeLostPulse = life_lost_q;
    assign shipBlink     = (phase_q == StCooldown) && cnt_q[2];

endmodule
